// File: rtl/cpld_iocfg_if.sv
// Z80 bus signals seen by the I/O config CPLD: the CPU drives them, the CPLD samples them.
// All strobes are active-low.
interface cpld_iocfg_if;
    logic       iorq_b;
    logic       wr_b;
    logic       m1_b;
    logic       mreq_b;
    logic       adr15;
    logic       adr8;
    logic [7:0] data;

    modport master (output iorq_b, wr_b, m1_b, mreq_b, adr15, adr8, data);
    modport slave  (input  iorq_b, wr_b, m1_b, mreq_b, adr15, adr8, data);
endinterface

// File: rtl/cpld_iocfg.sv
// Gate-array port decoder: filters Z80 I/O writes and commits RAM/ROM config once per I/O cycle.
// Latency: 4 clk from first qualify to outputs (IDLE->ARM->HOLD->COMMIT); commit waits for mreq_b high.
// Optional macro PORT_7EXX_EN enables the 7Exx low/high RAM select; otherwise low_not_high_ram_q is 0.
module cpld_iocfg (
    input  logic               clk,
    input  logic               reset_b_w,
    cpld_iocfg_if.slave        z80,
    input  logic               ram1mb_mode,
    input  logic               ram64kb_mode,
    input  logic               shadow_mode,
    output logic [5:0]         ramblock_q,
    output logic               mode3_q,
    output logic               low_not_high_ram_q,
    output logic               urom_disable_q,
    output logic               lrom_disable_q,
    output logic               cfg_upd
);

    typedef enum logic [1:0] {IDLE, ARM, HOLD, COMMIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] stg_dat_q, stg_dat_d;
    logic [5:0] ramblock_d;
    logic       mode3_d;
    logic       urom_disable_d;
    logic       lrom_disable_d;
    logic       cfg_upd_q, cfg_upd_d;
    logic [2:0] bank;
    logic       qualify;
`ifdef PORT_7EXX_EN
    logic       stg_adr8_q, stg_adr8_d;
    logic       low_not_high_ram_d;
`endif

    // m1_b low with iorq_b low is an interrupt acknowledge, never a port write
    assign qualify = !z80.iorq_b && !z80.wr_b && z80.m1_b && !z80.adr15 && z80.data[7];
    assign cfg_upd = cfg_upd_q;

    always_comb begin
        state_d        = state_q;
        stg_dat_d      = stg_dat_q;
        ramblock_d     = ramblock_q;
        mode3_d        = mode3_q;
        urom_disable_d = urom_disable_q;
        lrom_disable_d = lrom_disable_q;
        cfg_upd_d      = 1'b0;
        bank           = 3'b000;
`ifdef PORT_7EXX_EN
        stg_adr8_d         = stg_adr8_q;
        low_not_high_ram_d = low_not_high_ram_q;
`endif
        case (state_q)
            IDLE: begin
                if (qualify) state_d = ARM;
            end
            ARM: begin
                // second consecutive qualify filters single-clock glitches
                if (qualify) begin
                    state_d   = HOLD;
                    stg_dat_d = z80.data;
`ifdef PORT_7EXX_EN
                    stg_adr8_d = z80.adr8;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (z80.iorq_b) state_d = COMMIT;
            end
            COMMIT: begin
                // commit is deferred while a memory cycle is in flight
                if (z80.mreq_b) begin
                    state_d   = IDLE;
                    cfg_upd_d = 1'b1;
                    if (stg_dat_q[7:6] == 2'b11) begin
                        bank = ram64kb_mode ? 3'b000 : stg_dat_q[5:3];
                        if (shadow_mode && bank == 3'b111) bank = 3'b110;
                        ramblock_d = {bank, stg_dat_q[2:0]};
                        mode3_d    = (stg_dat_q[2:0] == 3'b011);
`ifdef PORT_7EXX_EN
                        low_not_high_ram_d = ram1mb_mode && !stg_adr8_q;
`endif
                    end else if (stg_dat_q[7:6] == 2'b10) begin
                        urom_disable_d = stg_dat_q[3];
                        lrom_disable_d = stg_dat_q[2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b_w) begin
        if (!reset_b_w) begin
            state_q        <= IDLE;
            stg_dat_q      <= 8'h00;
            ramblock_q     <= 6'b000000;
            mode3_q        <= 1'b0;
            urom_disable_q <= 1'b0;
            lrom_disable_q <= 1'b0;
            cfg_upd_q      <= 1'b0;
`ifdef PORT_7EXX_EN
            stg_adr8_q         <= 1'b0;
            low_not_high_ram_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            stg_dat_q      <= stg_dat_d;
            ramblock_q     <= ramblock_d;
            mode3_q        <= mode3_d;
            urom_disable_q <= urom_disable_d;
            lrom_disable_q <= lrom_disable_d;
            cfg_upd_q      <= cfg_upd_d;
`ifdef PORT_7EXX_EN
            stg_adr8_q         <= stg_adr8_d;
            low_not_high_ram_q <= low_not_high_ram_d;
`endif
        end
    end

`ifndef PORT_7EXX_EN
    assign low_not_high_ram_q = 1'b0;
`endif

endmodule

// File: tb/tb_cpld_iocfg.sv
// Bench for cpld_iocfg: directed Z80 port writes, expected config pushed to a queue,
// popped and compared by a monitor on every cfg_upd pulse.
module tb_cpld_iocfg;

    typedef struct packed {
        logic [5:0] rb;
        logic       m3;
        logic       lnh;
        logic       urom;
        logic       lrom;
    } obs_t;

`ifdef PORT_7EXX_EN
    localparam logic LNH_7EXX = 1'b1;
`else
    localparam logic LNH_7EXX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_b_w = 1'b0;
    logic       ram1mb_mode = 1'b0;
    logic       ram64kb_mode = 1'b0;
    logic       shadow_mode = 1'b0;
    logic [5:0] ramblock_q;
    logic       mode3_q, low_not_high_ram_q, urom_disable_q, lrom_disable_q, cfg_upd;

    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    obs_t mon_e;

    cpld_iocfg_if bus ();

    cpld_iocfg dut (
        .clk                (clk),
        .reset_b_w          (reset_b_w),
        .z80                (bus.slave),
        .ram1mb_mode        (ram1mb_mode),
        .ram64kb_mode       (ram64kb_mode),
        .shadow_mode        (shadow_mode),
        .ramblock_q         (ramblock_q),
        .mode3_q            (mode3_q),
        .low_not_high_ram_q (low_not_high_ram_q),
        .urom_disable_q     (urom_disable_q),
        .lrom_disable_q     (lrom_disable_q),
        .cfg_upd            (cfg_upd)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {ramblock_q, mode3_q, low_not_high_ram_q, urom_disable_q, lrom_disable_q};
    endfunction

    always @(negedge clk) begin
        if (cfg_upd === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cfg_upd: got outputs %h, no commit expected", observe());
            end else begin
                mon_e = exp_q.pop_front();
                if (observe() !== mon_e) begin
                    failures++;
                    $display("FAIL commit_values: got %h want %h", observe(), mon_e);
                end
            end
        end
    end

    task automatic check_state(input string name, input obs_t e);
        checks++;
        if (observe() !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, observe(), e);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, e);
        end
    endtask

    task automatic bus_idle();
        bus.iorq_b = 1'b1;
        bus.wr_b   = 1'b1;
        bus.m1_b   = 1'b1;
        bus.mreq_b = 1'b1;
        bus.adr15  = 1'b1;
        bus.adr8   = 1'b1;
        bus.data   = 8'h00;
    endtask

    task automatic drive_write(input logic [7:0] d, input logic a8);
        bus.iorq_b = 1'b0;
        bus.wr_b   = 1'b0;
        bus.adr15  = 1'b0;
        bus.adr8   = a8;
        bus.data   = d;
    endtask

    task automatic io_write(input logic [7:0] d, input logic a8, input int qclks);
        @(negedge clk);
        drive_write(d, a8);
        repeat (qclks) @(posedge clk);
        @(negedge clk);
        bus.iorq_b = 1'b1;
        bus.wr_b   = 1'b1;
        bus.adr15  = 1'b1;
    endtask

    // bounded wait: any expected commit not seen by now is a failure
    task automatic wait_commit(input string name);
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d commit(s) missing, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus_idle();
        repeat (3) @(negedge clk);
        check_state("reset_outputs", '0);
        check_bit("reset_cfg_upd", cfg_upd, 1'b0);
        reset_b_w = 1'b1;

        // C4 to 7Fxx: bank 000, config 100
        exp_q.push_back('{rb: 6'b000100, m3: 1'b0, lnh: 1'b0, urom: 1'b0, lrom: 1'b0});
        io_write(8'hC4, 1'b1, 2);
        wait_commit("write_C4");

        // FB in shadow mode: bank 111 remapped to 110
        shadow_mode = 1'b1;
        exp_q.push_back('{rb: 6'b110011, m3: 1'b1, lnh: 1'b0, urom: 1'b0, lrom: 1'b0});
        io_write(8'hFB, 1'b1, 2);
        wait_commit("write_FB_shadow");

        ram64kb_mode = 1'b1;
        exp_q.push_back('{rb: 6'b000011, m3: 1'b1, lnh: 1'b0, urom: 1'b0, lrom: 1'b0});
        io_write(8'hFB, 1'b1, 2);
        wait_commit("write_FB_64k");
        ram64kb_mode = 1'b0;
        shadow_mode  = 1'b0;

        // ROM control leaves RAM fields alone
        exp_q.push_back('{rb: 6'b000011, m3: 1'b1, lnh: 1'b0, urom: 1'b1, lrom: 1'b1});
        io_write(8'h8C, 1'b1, 2);
        wait_commit("write_8C_rom");

        io_write(8'hC2, 1'b1, 1);
        repeat (5) @(negedge clk);
        check_state("glitch_no_change", '{rb: 6'b000011, m3: 1'b1, lnh: 1'b0, urom: 1'b1, lrom: 1'b1});

        // 7Exx with 1MB mode: RAM commit keeps ROM bits
        ram1mb_mode = 1'b1;
        exp_q.push_back('{rb: 6'b000010, m3: 1'b0, lnh: LNH_7EXX, urom: 1'b1, lrom: 1'b1});
        io_write(8'hC2, 1'b0, 2);
        wait_commit("write_C2_7exx");
        ram1mb_mode = 1'b0;

        // commit deferred while mreq_b low for 3 clocks
        @(negedge clk);
        drive_write(8'hC5, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.iorq_b = 1'b1;
        bus.wr_b   = 1'b1;
        bus.adr15  = 1'b1;
        bus.mreq_b = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_state("mreq_hold", '{rb: 6'b000010, m3: 1'b0, lnh: LNH_7EXX, urom: 1'b1, lrom: 1'b1});
        end
        exp_q.push_back('{rb: 6'b000101, m3: 1'b0, lnh: 1'b0, urom: 1'b1, lrom: 1'b1});
        bus.mreq_b = 1'b1;
        wait_commit("write_C5_mreq");

        // interrupt acknowledge must not qualify
        @(negedge clk);
        bus.m1_b = 1'b0;
        drive_write(8'hC0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_idle();
        repeat (5) @(negedge clk);
        check_state("m1_ignored", '{rb: 6'b000101, m3: 1'b0, lnh: 1'b0, urom: 1'b1, lrom: 1'b1});

        // reset while HOLD discards the staged C7
        @(negedge clk);
        drive_write(8'hC7, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_b_w = 1'b0;
        #1;
        check_state("reset_in_hold", '0);
        check_bit("reset_in_hold_cfg_upd", cfg_upd, 1'b0);
        bus_idle();
        @(negedge clk);
        reset_b_w = 1'b1;
        repeat (6) @(negedge clk);
        check_state("after_reset_release", '0);

        exp_q.push_back('{rb: 6'b000000, m3: 1'b0, lnh: 1'b0, urom: 1'b0, lrom: 1'b1});
        io_write(8'h86, 1'b1, 2);
        wait_commit("write_86_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpld_iocfg.md
CPLD_IOCFG -- requirements
Module: cpld_iocfg

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state updates on posedge.
REQ-002 SHALL have port reset_b_w, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port iorq_b, input, 1: Z80 I/O request, active-low.
REQ-004 SHALL have port wr_b, input, 1: Z80 write strobe, active-low.
REQ-005 SHALL have port m1_b, input, 1: Z80 M1; low with iorq_b low marks an interrupt acknowledge, never an I/O write.
REQ-006 SHALL have port mreq_b, input, 1: Z80 memory request, active-low.
REQ-007 SHALL have port adr15, input, 1: address bit 15; 0 selects the gate-array port range.
REQ-008 SHALL have port adr8, input, 1: address bit 8; 0 = 7Exx, 1 = 7Fxx.
REQ-009 SHALL have port data, input, 8: Z80 data bus.
REQ-010 SHALL have ports ram1mb_mode, ram64kb_mode, shadow_mode, input, 1 each: DIP-derived static modes.
REQ-011 SHALL have port ramblock_q, output, 6: [5:3] = expansion bank, [2:0] = 7Fxx config.
REQ-012 SHALL have ports mode3_q, low_not_high_ram_q, urom_disable_q, lrom_disable_q, output, 1 each.
REQ-013 SHALL have port cfg_upd, output, 1: one-clk pulse when new values are committed.

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, ARM, HOLD, COMMIT.
REQ-015 Qualify = !iorq_b & !wr_b & m1_b & !adr15 & data[7].
REQ-016 IDLE -> ARM on posedge when qualify=1.
REQ-017 ARM -> HOLD when qualify is still 1, capturing data[7:0] and adr8 into staging; ARM -> IDLE otherwise (glitch filter, no update).
REQ-018 HOLD -> COMMIT on the first posedge with iorq_b=1; exactly one capture per I/O cycle.
REQ-019 COMMIT: when mreq_b=1, outputs update and cfg_upd=1 for that clock, then -> IDLE; when mreq_b=0, stay in COMMIT with outputs unchanged.
REQ-020 Staged data[7:6]=11 (RAM control): bank = ram64kb_mode ? 000 : data[5:3]; in shadow_mode a bank of 111 SHALL become 110; ramblock_q = {bank, data[2:0]}; mode3_q = (data[2:0]==011).
REQ-021 Staged data[7:6]=10 (ROM control): urom_disable_q = data[3], lrom_disable_q = data[2]; RAM fields unchanged.
REQ-022 A RAM-control commit SHALL leave the ROM bits unchanged.
REQ-023 qualify events in ARM/HOLD/COMMIT other than the transitions above SHALL be ignored; no queueing.
REQ-024 Minimum latency, qualify first seen to outputs valid: 4 posedges with iorq_b released at the 3rd.

Reset
REQ-025 reset_b_w low SHALL asynchronously force FSM=IDLE, staging=0, ramblock_q=000000, mode3_q=0, low_not_high_ram_q=0, urom_disable_q=0, lrom_disable_q=0, cfg_upd=0.
REQ-026 Reset during ARM/HOLD/COMMIT SHALL discard the staged write; no commit after release.
REQ-027 First qualify SHALL be sampled at the first posedge after reset_b_w rises.

Configuration
REQ-028 Macro PORT_7EXX_EN defined: on RAM-control commit, low_not_high_ram_q = ram1mb_mode & !staged_adr8.
REQ-029 Macro PORT_7EXX_EN undefined: low_not_high_ram_q SHALL be constant 0 and adr8 SHALL be unused.

Verification
REQ-030 Reset, then I/O write 7Fxx data=C4 (qualify 2 clks, iorq_b high, mreq_b=1) -> ramblock_q=000100, mode3_q=0, cfg_upd pulses once.
REQ-031 shadow_mode=1, write data=FB -> ramblock_q=110011, mode3_q=1; with ram64kb_mode=1 -> ramblock_q=000011.
REQ-032 Write data=8C -> urom_disable_q=1, lrom_disable_q=1, ramblock_q unchanged; 1-clk iorq_b low glitch with data=C2 -> no change, no cfg_upd.
REQ-033 PORT_7EXX_EN defined, ram1mb_mode=1, write 7Exx data=C2 -> low_not_high_ram_q=1; undefined -> 0.
REQ-034 Hold mreq_b=0 for 3 clks in COMMIT -> outputs held, cfg_upd delayed until mreq_b=1; m1_b=0 with iorq_b low -> ignored.
REQ-035 Assert reset_b_w in HOLD after data=C7 -> all outputs 0, no cfg_upd after release.
